// File: rtl/comp_serial_ctrl.sv
// -----------------------------------------------------------------------------
// comp_serial_ctrl
// Sequential unsigned magnitude comparator. Two WIDTH-bit operands are captured
// on an accepted start and compared two bits per clock, most significant slice
// first, through one shared 2-bit compare slice. The walk stops at the first
// unequal slice. The result is reported as one-hot {lg, eq, sm} with a
// start/busy/done handshake.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      compare request, sampled only while busy is low
//   a      in   WIDTH  operand X, captured on the accepted start edge
//   b      in   WIDTH  operand Y, captured on the accepted start edge
//   busy   out  1      high while a compare is running or being reported
//   done   out  1      one-cycle pulse, result valid on lg/eq/sm
//   lg     out  1      X > Y, held until the next result
//   eq     out  1      X == Y, held until the next result
//   sm     out  1      X < Y, held until the next result
// -----------------------------------------------------------------------------
module comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lg,
  output logic             eq,
  output logic             sm
);

  localparam int DIGITS = WIDTH / 2;
  localparam int IDXW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // One 2-bit slice compare, one-hot {greater, equal, smaller}.
  function automatic logic [2:0] slice_cmp(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] r;
    if (x > y) begin
      r = 3'b100;
    end else if (x < y) begin
      r = 3'b001;
    end else begin
      r = 3'b010;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [2:0]       res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       slice_res;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    idx_d     = idx_q;
    res_d     = res_q;
    slice_res = slice_cmp(sa_q[WIDTH-1 -: 2], sb_q[WIDTH-1 -: 2]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          idx_d   = IDXW'(DIGITS - 1);
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (slice_res != 3'b010) begin
          // First unequal slice decides the whole compare.
          res_d   = slice_res;
          state_d = S_DONE;
        end else if (idx_q == {IDXW{1'b0}}) begin
          // Every slice matched; idx never wraps so this always exits.
          res_d   = 3'b010;
          state_d = S_DONE;
        end else begin
          sa_d    = sa_q << 2;
          sb_d    = sb_q << 2;
          idx_d   = idx_q - IDXW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, shift registers, slice counter and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= {WIDTH{1'b0}};
      sb_q    <= {WIDTH{1'b0}};
      idx_q   <= {IDXW{1'b0}};
      res_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign lg   = res_q[2];
  assign eq   = res_q[1];
  assign sm   = res_q[0];

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comp_serial_ctrl
// Scoreboard bench for comp_serial_ctrl (WIDTH=8). A reference process models
// acceptance of start at each rising edge and pushes the expected result and
// the edge at which done must appear. A monitor on the falling edge checks
// busy, done and the held result against that expectation.
// -----------------------------------------------------------------------------
module tb_comp_serial_ctrl;

  localparam int WIDTH  = 8;
  localparam int DIGITS = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_i = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy, done, lg, eq, sm;

  comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_i),
    .a     (a_i),
    .b     (b_i),
    .busy  (busy),
    .done  (done),
    .lg    (lg),
    .eq    (eq),
    .sm    (sm)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         done_cnt;
    logic [2:0] res;
  } exp_t;

  exp_t       exp_q[$];
  int         cnt = 0;
  int         next_free = 0;
  logic [2:0] res_model = 3'b000;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cnt, act, req);
    end
  endtask

  // Number of slices visited: position of the highest differing bit, or all.
  function automatic int model_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] d;
    int k;
    d = x ^ y;
    k = DIGITS;
    for (int p = 0; p < WIDTH; p++) begin
      if (d[p]) k = (WIDTH - 1 - p) / 2 + 1;
    end
    return k;
  endfunction

  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
    return 3'b010;
  endfunction

  // Reference: count edges and decide when a start is accepted.
  initial begin
    exp_t e;
    int k;
    forever begin
      @(posedge clk);
      cnt++;
      if (!rst_n) begin
        next_free = 0;
      end else if (start_i && cnt >= next_free) begin
        k = model_k(a_i, b_i);
        e.done_cnt = cnt + k;
        e.res      = model_res(a_i, b_i);
        exp_q.push_back(e);
        next_free = cnt + k + 2;
      end
    end
  end

  // Monitor: compare outputs with the expectation on every falling edge.
  initial begin
    logic done_exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        res_model = 3'b000;
      end
      done_exp = (exp_q.size() > 0) && (exp_q[0].done_cnt == cnt);
      chk("busy", {31'd0, busy}, {31'd0, (cnt <= next_free - 2)});
      chk("done", {31'd0, done}, {31'd0, done_exp});
      if (done_exp) begin
        res_model = exp_q[0].res;
        void'(exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0].done_cnt < cnt) begin
        void'(exp_q.pop_front());
      end
      chk("result", {29'd0, lg, eq, sm}, {29'd0, res_model});
    end
  end

  task automatic wait_free();
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    while (cnt + 1 < next_free && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
  endtask

  task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input int hold);
    wait_free();
    a_i = x;
    b_i = y;
    start_i = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {27'd0, busy, done, lg, eq, sm}, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] x, y;
    int mode;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    issue(8'hA5, 8'hA5, 1);
    issue(8'hC0, 8'h40, 1);
    issue(8'h12, 8'h13, 1);

    // Start held and operand changed while running.
    wait_free();
    a_i = 8'h30;
    b_i = 8'h20;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    a_i = 8'h00;
    repeat (6) @(posedge clk);
    #1;
    start_i = 1'b0;

    // Back-to-back with start held high.
    wait_free();
    a_i = 8'h01;
    b_i = 8'h02;
    start_i = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    start_i = 1'b0;

    // Mid-cycle reset while idle with a result held.
    do_reset();

    // Abort a running compare with reset.
    wait_free();
    a_i = 8'h55;
    b_i = 8'h56;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(posedge clk);
    do_reset();
    issue(8'hFF, 8'h00, 1);

    for (int i = 0; i < 40; i++) begin
      x = WIDTH'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) y = WIDTH'($urandom);
      else if (mode == 1) y = x;
      else y = x ^ (8'h01 << $urandom_range(0, 7));
      issue(x, y, $urandom_range(1, 3));
      a_i = WIDTH'($urandom);
      b_i = WIDTH'($urandom);
    end

    repeat (12) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
